acc_responder_ideal: RTL and testbench
======================================

ACC_RESPONDER_IDEAL -- requirements
Module: acc_responder_ideal

Interface
REQ-001 SHALL have parameter XLEN, default 64, scalar operand/result width.
REQ-002 SHALL have parameter DEPTH, default 4, request FIFO entries (power of two, >=2).
REQ-003 SHALL have parameter LATENCY, default 3, execute cycles per request (>=1).
REQ-004 SHALL have port clk_i  input  1  single clock, rising edge.
REQ-005 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_valid_i  input  1  dispatcher request valid.
REQ-007 SHALL have port req_ready_o  output  1  responder can accept a request.
REQ-008 SHALL have port req_insn_i  input  32  instruction word.
REQ-009 SHALL have port req_rs1_i  input  XLEN  scalar operand 1.
REQ-010 SHALL have port req_rs2_i  input  XLEN  scalar operand 2.
REQ-011 SHALL have port req_trans_id_i  input  3  transaction tag.
REQ-012 SHALL have port resp_valid_o  output  1  response valid.
REQ-013 SHALL have port resp_ready_i  input  1  dispatcher accepts response.
REQ-014 SHALL have port resp_result_o  output  XLEN  result.
REQ-015 SHALL have port resp_trans_id_o  output  3  echoed tag.
REQ-016 SHALL have port resp_error_o  output  1  illegal instruction.
REQ-017 SHALL have port idle_o  output  1  FIFO empty and FSM in IDLE.
REQ-018 SHALL have port accepted_cnt_o  output  32  accepted-request count.
REQ-019 SHALL have port proto_err_o  output  1  sticky protocol-violation flag.

Function
REQ-020 Request handshake SHALL occur on a rising edge with req_valid_i && req_ready_o; payload pushed into FIFO.
REQ-021 req_ready_o SHALL equal FIFO not full; no bypass, so a full FIFO blocks even when a pop occurs the same cycle.
REQ-022 Simultaneous push and pop on a non-full FIFO SHALL leave occupancy unchanged; pointers SHALL wrap modulo DEPTH.
REQ-023 FSM states SHALL be IDLE, WAIT, RESP.
REQ-024 IDLE -> WAIT when FIFO non-empty, loading counter with LATENCY-1; IDLE otherwise held.
REQ-025 WAIT SHALL decrement counter each cycle; at counter 0 -> RESP; WAIT lasts exactly LATENCY cycles.
REQ-026 In RESP, resp_valid_o=1 and outputs SHALL be driven from FIFO head, stable until resp_ready_i.
REQ-027 Response handshake (resp_valid_o && resp_ready_i) SHALL pop head; then -> WAIT (reload LATENCY-1) if entries remain after pop, else -> IDLE.
REQ-028 With an empty idle block, request accepted at edge E0 SHALL produce resp_valid_o=1 after edge E0+LATENCY+1 (4 cycles at default).
REQ-029 If insn[6:0]==7'h57, result SHALL be rs1+rs2 modulo 2^XLEN, error=0; otherwise result=0, error=1.
REQ-030 resp_trans_id_o SHALL equal the tag of the head entry; responses in acceptance order.
REQ-031 resp_result_o, resp_trans_id_o, resp_error_o SHALL be 0 when resp_valid_o=0.
REQ-032 accepted_cnt_o SHALL increment by 1 per request handshake, wrapping 2^32-1 -> 0.
REQ-033 idle_o SHALL be combinational: FIFO empty and FSM==IDLE.

Reset
REQ-034 rst_i=1 SHALL immediately force: FSM IDLE, FIFO empty, counter 0, accepted_cnt_o 0, proto_err_o 0, resp_valid_o 0, req_ready_o 1 (from empty FIFO), idle_o 1.
REQ-035 Reset mid-operation SHALL discard all queued and in-flight requests; no response issued for them after release.

Configuration
REQ-036 Macro ACC_RESP_CHECK_EN defined: proto_err_o SHALL set (sticky until reset) when, on a cycle with req_valid_i=1 and req_ready_o=0, the next cycle shows req_valid_i=0 or any change of insn/rs1/rs2/trans_id.
REQ-037 Macro ACC_RESP_CHECK_EN undefined: proto_err_o SHALL be constant 0 and no check logic synthesised.

Verification
REQ-038 Single request insn=32'h00000057, rs1=5, rs2=7, id=2, resp_ready_i=1 -> resp_valid_o after 4 edges, result=12, id=2, error=0, one-cycle pulse.
REQ-039 insn=32'h00000033 -> result=0, error=1; rs1=2^64-1, rs2=2 with OP-V -> result=1.
REQ-040 resp_ready_i=0, push 4 requests -> req_ready_o=0 after 4th; 5th held valid until first pop; responses ids in order 0..4.
REQ-041 Back-to-back stream, resp_ready_i=1 -> successive resp_valid_o pulses spaced LATENCY+1 cycles; accepted_cnt_o matches count.
REQ-042 Assert rst_i during WAIT with 3 queued -> resp_valid_o=0 asynchronously, idle_o=1, accepted_cnt_o=0, no later responses.
REQ-043 With ACC_RESP_CHECK_EN, full FIFO, drop req_valid_i before ready -> proto_err_o=1 and stays 1; without macro -> proto_err_o=0.

Source files
------------

// File: rtl/acc_responder_ideal.sv
// acc_responder_ideal: queued accelerator responder with a fixed execute latency per request.
// Optional protocol checker on the request channel is built when ACC_RESP_CHECK_EN is defined.
module acc_responder_ideal #(
    parameter int XLEN    = 64,
    parameter int DEPTH   = 4,
    parameter int LATENCY = 3
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [31:0]     req_insn_i,
    input  logic [XLEN-1:0] req_rs1_i,
    input  logic [XLEN-1:0] req_rs2_i,
    input  logic [2:0]      req_trans_id_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] resp_result_o,
    output logic [2:0]      resp_trans_id_o,
    output logic            resp_error_o,
    output logic            idle_o,
    output logic [31:0]     accepted_cnt_o,
    output logic            proto_err_o
);
    // state  | meaning
    // S_IDLE | FIFO empty, nothing in execution
    // S_WAIT | head entry executing, latency counter running down
    // S_RESP | head result presented until the dispatcher takes it
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] LAT_INIT = CW'(LATENCY - 1);

    state_t          state;
    logic [CW-1:0]   lat_cnt;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [PW:0]     count, count_next;
    logic            push, pop, full, is_op_v;

    logic [XLEN-1:0] mem_result [DEPTH];
    logic [2:0]      mem_id     [DEPTH];
    logic            mem_err    [DEPTH];

    // Only the major opcode decides legality; the upper instruction bits are ignored.
    logic unused_insn_bits;
    assign unused_insn_bits = ^req_insn_i[31:7];

    assign full        = (count == (PW+1)'(DEPTH));
    assign req_ready_o = !full;
    assign push        = req_valid_i && req_ready_o;
    assign pop         = resp_valid_o && resp_ready_i;
    assign is_op_v     = (req_insn_i[6:0] == 7'h57);
    assign idle_o      = (count == '0) && (state == S_IDLE);

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + (PW+1)'(1);
        else if (!push && pop)
            count_next = count - (PW+1)'(1);
    end

    // The result is computed at acceptance; the latency is purely a timing model.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_result[wr_ptr] <= is_op_v ? (req_rs1_i + req_rs2_i) : '0;
            mem_id[wr_ptr]     <= req_trans_id_i;
            mem_err[wr_ptr]    <= !is_op_v;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            accepted_cnt_o <= '0;
        end else begin
            count <= count_next;
            if (push) begin
                wr_ptr         <= wr_ptr + PW'(1);
                accepted_cnt_o <= accepted_cnt_o + 32'd1;
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= S_IDLE;
            lat_cnt      <= '0;
            resp_valid_o <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (count != '0) begin
                        state   <= S_WAIT;
                        lat_cnt <= LAT_INIT;
                    end
                end
                S_WAIT: begin
                    if (lat_cnt == '0) begin
                        state        <= S_RESP;
                        resp_valid_o <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt - CW'(1);
                    end
                end
                S_RESP: begin
                    if (resp_ready_i) begin
                        resp_valid_o <= 1'b0;
                        // A push landing on the same edge counts as a remaining entry.
                        if (count_next != '0) begin
                            state   <= S_WAIT;
                            lat_cnt <= LAT_INIT;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state        <= S_IDLE;
                    resp_valid_o <= 1'b0;
                end
            endcase
        end
    end

    assign resp_result_o   = resp_valid_o ? mem_result[rd_ptr] : '0;
    assign resp_trans_id_o = resp_valid_o ? mem_id[rd_ptr]     : '0;
    assign resp_error_o    = resp_valid_o ? mem_err[rd_ptr]    : 1'b0;

`ifdef ACC_RESP_CHECK_EN
    logic                    stall_q;
    logic [32+2*XLEN+3-1:0]  payload_q;
    logic [32+2*XLEN+3-1:0]  payload;

    assign payload = {req_insn_i, req_rs1_i, req_rs2_i, req_trans_id_i};

    // A stalled request must stay valid with an unchanged payload on the following cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_q     <= 1'b0;
            payload_q   <= '0;
            proto_err_o <= 1'b0;
        end else begin
            stall_q   <= req_valid_i && !req_ready_o;
            payload_q <= payload;
            if (stall_q && (!req_valid_i || (payload != payload_q)))
                proto_err_o <= 1'b1;
        end
    end
`else
    assign proto_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_acc_responder_ideal.sv
// Bench for acc_responder_ideal: queue-based reference model checked every cycle plus directed scenarios.
// Protocol-check expectations follow ACC_RESP_CHECK_EN when it is defined for the build.
module tb_acc_responder_ideal;
    localparam int XLEN    = 64;
    localparam int DEPTH   = 4;
    localparam int LATENCY = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready_o;
    logic [31:0]     req_insn = '0;
    logic [XLEN-1:0] req_rs1 = '0;
    logic [XLEN-1:0] req_rs2 = '0;
    logic [2:0]      req_id = '0;
    logic            resp_valid_o;
    logic            resp_ready = 1'b0;
    logic [XLEN-1:0] resp_result_o;
    logic [2:0]      resp_trans_id_o;
    logic            resp_error_o;
    logic            idle_o;
    logic [31:0]     accepted_cnt_o;
    logic            proto_err_o;

    always #5 clk = ~clk;

    acc_responder_ideal #(.XLEN(XLEN), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready_o),
        .req_insn_i(req_insn), .req_rs1_i(req_rs1), .req_rs2_i(req_rs2),
        .req_trans_id_i(req_id),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready),
        .resp_result_o(resp_result_o), .resp_trans_id_o(resp_trans_id_o),
        .resp_error_o(resp_error_o), .idle_o(idle_o),
        .accepted_cnt_o(accepted_cnt_o), .proto_err_o(proto_err_o)
    );

    typedef struct {
        logic [XLEN-1:0] res;
        logic [2:0]      id;
        logic            err;
    } ent_t;

    ent_t        q[$];
    logic [2:0]  got_ids[$];
    int          pop_edges[$];
    int          checks = 0;
    int          failures = 0;
    int          e = 0;
    int          valid_edge = 0;
    int          pushed = 0;
    logic [31:0] acc_m = '0;
    logic        exp_perr = 1'b0;
    logic        pstall = 1'b0;
    logic [32+2*XLEN+3-1:0] ppay = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: bound expired, got no event expected event (t=%0t)", name, $time);
    endtask

    // Reference model: evaluated between edges, predicts the next rising edge.
    always @(negedge clk) begin
        logic            mv, mr, do_push, do_pop;
        logic [XLEN-1:0] er;
        logic [2:0]      eid;
        logic            ee;
        ent_t            n;
        if (rst) begin
            q.delete();
            acc_m    = '0;
            exp_perr = 1'b0;
            pstall   = 1'b0;
        end
        mv  = (q.size() > 0) && (e >= valid_edge);
        mr  = (q.size() < DEPTH);
        er  = '0;
        eid = '0;
        ee  = 1'b0;
        if (mv) begin
            er  = q[0].res;
            eid = q[0].id;
            ee  = q[0].err;
        end
        chk("resp_valid", resp_valid_o, mv);
        chk("resp_result", resp_result_o, er);
        chk("resp_id", resp_trans_id_o, eid);
        chk("resp_error", resp_error_o, ee);
        chk("req_ready", req_ready_o, mr);
        chk("idle", idle_o, q.size() == 0);
        chk("accepted_cnt", accepted_cnt_o, acc_m);
        chk("proto_err", proto_err_o, exp_perr);
        if (!rst) begin
            if (resp_valid_o && resp_ready) begin
                got_ids.push_back(resp_trans_id_o);
                pop_edges.push_back(e);
            end
`ifdef ACC_RESP_CHECK_EN
            if (pstall && (!req_valid || ({req_insn, req_rs1, req_rs2, req_id} != ppay)))
                exp_perr = 1'b1;
            pstall = req_valid && !mr;
            ppay   = {req_insn, req_rs1, req_rs2, req_id};
`endif
            do_push = req_valid && mr;
            do_pop  = mv && resp_ready;
            if (do_pop) begin
                void'(q.pop_front());
                if (q.size() > 0 || do_push)
                    valid_edge = e + 1 + LATENCY;
            end
            if (do_push) begin
                if (q.size() == 0 && !do_pop)
                    valid_edge = e + 1 + LATENCY + 1;
                n.id  = req_id;
                n.err = (req_insn[6:0] != 7'h57);
                n.res = n.err ? '0 : req_rs1 + req_rs2;
                q.push_back(n);
                acc_m = acc_m + 32'd1;
            end
        end
        e++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] insn, input logic [63:0] a, input logic [63:0] b,
                        input logic [2:0] id);
        logic r;
        int   n;
        req_valid = 1'b1;
        req_insn  = insn;
        req_rs1   = a;
        req_rs2   = b;
        req_id    = id;
        n = 0;
        do begin
            r = req_ready_o;
            cyc();
            n++;
        end while (!r && n < 200);
        if (!r) timeout("push_accept");
        req_valid = 1'b0;
        pushed++;
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        while (!resp_valid_o && k < 100) begin
            cyc();
            k++;
        end
        if (!resp_valid_o) timeout("wait_valid");
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (!idle_o && k < 300) begin
            cyc();
            k++;
        end
        if (!idle_o) timeout("wait_idle");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int bad;
        #1;
        chk("rst_valid", resp_valid_o, 0);
        chk("rst_ready", req_ready_o, 1);
        chk("rst_idle", idle_o, 1);
        chk("rst_acc", accepted_cnt_o, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single OP-V request: latency and one-cycle pulse.
        resp_ready = 1'b1;
        push(32'h0000_0057, 64'd5, 64'd7, 3'd2);
        wait_valid(k);
        chk("single_latency", k, 4);
        chk("single_result", resp_result_o, 12);
        chk("single_id", resp_trans_id_o, 2);
        chk("single_err", resp_error_o, 0);
        cyc();
        chk("single_pulse", resp_valid_o, 0);

        // Illegal opcode, then wrap-around add.
        push(32'h0000_0033, 64'd9, 64'd9, 3'd5);
        wait_valid(k);
        chk("illegal_result", resp_result_o, 0);
        chk("illegal_err", resp_error_o, 1);
        chk("illegal_id", resp_trans_id_o, 5);
        cyc();
        push(32'hABCD_0057, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 3'd6);
        wait_valid(k);
        chk("wrap_result", resp_result_o, 1);
        chk("wrap_err", resp_error_o, 0);
        cyc();

        // Fill with back-pressure, fifth request held until the first pop.
        resp_ready = 1'b0;
        got_ids.delete();
        for (int i = 0; i < 4; i++) push(32'h57, 64'(i), 64'd1, 3'(i));
        chk("full_ready", req_ready_o, 0);
        req_valid = 1'b1;
        req_insn  = 32'h57;
        req_rs1   = 64'd4;
        req_rs2   = 64'd1;
        req_id    = 3'd4;
        repeat (6) cyc();
        chk("full_held_ready", req_ready_o, 0);
        resp_ready = 1'b1;
        push(32'h57, 64'd4, 64'd1, 3'd4);
        wait_idle();
        chk("order_count", got_ids.size(), 5);
        for (int i = 0; i < 5 && i < got_ids.size(); i++) chk("order_id", got_ids[i], i);

        // Back-to-back stream: pops spaced LATENCY+1 edges apart.
        pop_edges.delete();
        for (int i = 0; i < 6; i++) push(32'h1057, 64'(i * 3), 64'(i), 3'(i));
        wait_idle();
        chk("stream_count", pop_edges.size(), 6);
        for (int i = 1; i < 6 && i < pop_edges.size(); i++)
            chk("stream_spacing", pop_edges[i] - pop_edges[i-1], LATENCY + 1);
        chk("acc_total", accepted_cnt_o, pushed);
        chk("acc_14", accepted_cnt_o, 14);

        // Reset while the head is executing with three queued.
        for (int i = 0; i < 3; i++) push(32'h57, 64'd1, 64'd1, 3'(i + 1));
        rst = 1'b1;
        #1;
        chk("midrst_valid", resp_valid_o, 0);
        chk("midrst_idle", idle_o, 1);
        chk("midrst_acc", accepted_cnt_o, 0);
        chk("midrst_ready", req_ready_o, 1);
        cyc();
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (resp_valid_o) bad++;
        end
        chk("midrst_no_resp", bad, 0);

        // Drop a stalled request before it is accepted.
        resp_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(32'h57, 64'd2, 64'd3, 3'(i));
        req_valid = 1'b1;
        req_insn  = 32'h57;
        req_rs1   = 64'd8;
        req_rs2   = 64'd8;
        req_id    = 3'd7;
        repeat (2) cyc();
        req_valid = 1'b0;
        repeat (3) cyc();
`ifdef ACC_RESP_CHECK_EN
        chk("proto_set", proto_err_o, 1);
`else
        chk("proto_off", proto_err_o, 0);
`endif
        resp_ready = 1'b1;
        wait_idle();
        repeat (3) cyc();
`ifdef ACC_RESP_CHECK_EN
        chk("proto_sticky", proto_err_o, 1);
`else
        chk("proto_off_late", proto_err_o, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
